// File: rtl/spi_shadow_reg_bank_pkg.sv
// Shared types and helpers for the SPI register-bank receivers.
// Contents:
//   spi_state_t  - receiver FSM states (IDLE, SHIFT, DONE)
//   spi_dbg_t    - debug snapshot of the receiver (state, synced pins, bit count)
//   frame_width  - address + data bits in one SPI frame
//   cnt_width    - bit-counter width able to hold a full frame length
package spi_shadow_reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    typedef struct packed {
        spi_state_t  state;
        logic        sclk;
        logic        ss_n;
        logic [7:0]  count;
    } spi_dbg_t;

    function automatic int unsigned frame_width(input int unsigned addr_w,
                                                input int unsigned data_w);
        return addr_w + data_w;
    endfunction

    // Counter must represent the value FRAME_W itself, hence the +1.
    function automatic int unsigned cnt_width(input int unsigned frame_w);
        return $clog2(frame_w + 1);
    endfunction

endpackage

// File: rtl/spi_shadow_reg_bank_if.sv
// SPI pin bundle between a host (master) and the register bank (slave).
// Signals:
//   spi_sclk  - SPI clock, mode 0: data is sampled on the rising edge
//   spi_mosi  - serial data, MSB first
//   spi_ss_n  - frame select, active low
// Frame protocol: the host pulls spi_ss_n low, presents each bit on spi_mosi
// while spi_sclk is low and raises spi_sclk once per bit; a frame is
// ADDR_W+DATA_W bits. Releasing spi_ss_n before the last bit aborts the frame.
// Extra bits after a full frame are ignored. Between frames spi_ss_n stays high
// for at least SYNC_STAGES+2 receiver clocks. There is no back-pressure.
interface spi_shadow_reg_bank_if;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_ss_n;

    modport master (output spi_sclk, output spi_mosi, output spi_ss_n);
    modport slave  (input  spi_sclk, input  spi_mosi, input  spi_ss_n);
endinterface

// File: rtl/spi_shadow_reg_bank_sync_edge.sv
// Multi-flop synchroniser with rising-edge detector for one asynchronous pin.
// Ports:
//   clk, rst_n - receiver clock, synchronous active-low reset
//   d_i        - asynchronous input pin
//   sync_o     - synchronised level (SYNC_STAGES clk of latency)
//   rise_o     - high for one clk when sync_o goes 0 -> 1
// The chain resets to IDLE_VAL so that leaving reset never produces a
// spurious edge on a pin sitting at its idle level.
module spi_shadow_reg_bank_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {SYNC_STAGES{IDLE_VAL}};
            prev_q  <= IDLE_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/spi_shadow_reg_bank.sv
// SPI-slave register bank with frame-synchronous double-buffered commit.
// Ports:
//   clk, rst_n    - pixel clock, synchronous active-low reset
//   spi           - SPI pins (slave modport), asynchronous to clk
//   vblank        - clk-domain vertical-blank level
//   regs_out      - active registers, reg i at [i*DATA_W +: DATA_W]
//   pending       - per-register "staged write awaiting commit"
//   commit_pulse  - 1-clk strobe when staged values are copied to active
//   frame_err     - 1-clk strobe: ss_n released before a full frame
//   addr_err      - 1-clk strobe: full frame addressed a missing register
//   dbg_o         - receiver state, synced sclk/ss_n and bit count
// A frame is ADDR_W address bits then DATA_W data bits, both MSB first.
// With COMMIT_VBLANK=1 writes land in staging and move to the active set on
// the next vblank rise; with COMMIT_VBLANK=0 they move one clk after decode.
module spi_shadow_reg_bank
    import spi_shadow_reg_bank_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 4,
    parameter int unsigned       DATA_W        = 16,
    parameter int unsigned       NUM_REGS      = 8,
    parameter int unsigned       SYNC_STAGES   = 2,
    parameter bit                COMMIT_VBLANK = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL     = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_shadow_reg_bank_if.slave         spi,
    input  logic                         vblank,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          pending,
    output logic                         commit_pulse,
    output logic                         frame_err,
    output logic                         addr_err,
    output spi_dbg_t                     dbg_o
);

    localparam int unsigned FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = cnt_width(FRAME_W);

    // ---------------- pin synchronisers ----------------
    logic sclk_s, sclk_rise;
    logic ss_s, ss_rise;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_shadow_reg_bank_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d_i(spi.spi_sclk), .sync_o(sclk_s), .rise_o(sclk_rise)
    );

    spi_shadow_reg_bank_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .d_i(spi.spi_ss_n), .sync_o(ss_s), .rise_o(ss_rise)
    );

    // Same depth as the sclk chain so data and its clock edge stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ---------------- receiver FSM ----------------
    spi_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [FRAME_W-1:0]  shift_q;
    logic                frame_start, shift_en, frame_last, frame_abort;
    logic [FRAME_W-1:0]  frame_word;
    logic [ADDR_W-1:0]   frame_addr;
    logic [DATA_W-1:0]   frame_data;
    logic                addr_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start) state_d = SHIFT;
            SHIFT:   if (frame_abort) state_d = IDLE;
                     else if (frame_last) state_d = DONE;
            DONE:    if (ss_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In SHIFT the select was low on entry, so a high level appears as a rise.
    always_comb begin
        frame_start = (state_q == IDLE) && !ss_s;
        frame_abort = (state_q == SHIFT) && ss_rise;
        shift_en    = (state_q == SHIFT) && !ss_rise && sclk_rise;
        frame_last  = shift_en && (cnt_q == CNT_W'(FRAME_W - 1));
    end

    // Decode looks at the word including the bit arriving this cycle.
    assign frame_word = {shift_q[FRAME_W-2:0], mosi_s};
    assign frame_addr = frame_word[FRAME_W-1 -: ADDR_W];
    assign frame_data = frame_word[DATA_W-1:0];
    assign addr_ok    = (32'(frame_addr) < NUM_REGS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (frame_start) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (shift_en) begin
            cnt_q   <= cnt_q + 1'b1;
            shift_q <= frame_word;
        end
    end

    // ---------------- staging / commit ----------------
    logic [DATA_W-1:0]   staging_q [NUM_REGS];
    logic [DATA_W-1:0]   active_q  [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] write_vec;
    logic                vb_now_q, vb_prev_q, vb_rise;
    logic                commit_en;
    logic                commit_pulse_q, frame_err_q, addr_err_q;

    assign vb_rise   = vb_now_q & ~vb_prev_q;
    // Immediate mode commits any pending register on the very next clk.
    assign commit_en = COMMIT_VBLANK ? vb_rise : 1'b1;

    always_comb begin
        write_vec = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            write_vec[i] = frame_last && addr_ok && (frame_addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                staging_q[i] <= RESET_VAL;
                active_q[i]  <= RESET_VAL;
            end
            pending_q      <= '0;
            vb_now_q       <= 1'b0;
            vb_prev_q      <= 1'b0;
            commit_pulse_q <= 1'b0;
            frame_err_q    <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            vb_now_q  <= vblank;
            vb_prev_q <= vb_now_q;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                // Commit copies the old staged value; a write in the same cycle
                // replaces staging and keeps its pending bit for the next commit.
                if (commit_en && pending_q[i]) begin
                    active_q[i] <= staging_q[i];
                end
                if (write_vec[i]) begin
                    staging_q[i] <= frame_data;
                end
                pending_q[i] <= write_vec[i] | (pending_q[i] & ~commit_en);
            end
            commit_pulse_q <= COMMIT_VBLANK ? vb_rise : |pending_q;
            frame_err_q    <= frame_abort;
            addr_err_q     <= frame_last && !addr_ok;
        end
    end

    // ---------------- outputs ----------------
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign pending      = pending_q;
    assign commit_pulse = commit_pulse_q;
    assign frame_err    = frame_err_q;
    assign addr_err     = addr_err_q;

    always_comb begin
        dbg_o       = '0;
        dbg_o.state = state_q;
        dbg_o.sclk  = sclk_s;
        dbg_o.ss_n  = ss_s;
        dbg_o.count = 8'(cnt_q);
    end

endmodule

// File: tb/tb_spi_shadow_reg_bank.sv
// Directed bench for spi_shadow_reg_bank: one vblank-commit instance and one
// immediate-commit instance share the same SPI pins and vblank.
module tb_spi_shadow_reg_bank;
    import spi_shadow_reg_bank_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vblank = 1'b0;
    always #5 clk = ~clk;

    spi_shadow_reg_bank_if spi_bus ();

    logic [127:0] regs0, regs1;
    logic [7:0]   pend0, pend1;
    logic         cp0, cp1, fe0, fe1, ae0, ae1;
    spi_dbg_t     dbg0, dbg1;

    spi_shadow_reg_bank #(.COMMIT_VBLANK(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .spi(spi_bus.slave), .vblank(vblank),
        .regs_out(regs0), .pending(pend0), .commit_pulse(cp0),
        .frame_err(fe0), .addr_err(ae0), .dbg_o(dbg0)
    );

    spi_shadow_reg_bank #(.COMMIT_VBLANK(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .spi(spi_bus.slave), .vblank(vblank),
        .regs_out(regs1), .pending(pend1), .commit_pulse(cp1),
        .frame_err(fe1), .addr_err(ae1), .dbg_o(dbg1)
    );

    // ---------------- strobe counters (sampled on falling edge) ----------------
    int cp0_n = 0, cp1_n = 0, fe0_n = 0, ae0_n = 0;
    always @(negedge clk) begin
        if (cp0 === 1'b1) cp0_n++;
        if (cp1 === 1'b1) cp1_n++;
        if (fe0 === 1'b1) fe0_n++;
        if (ae0 === 1'b1) ae0_n++;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] reg_of(input logic [127:0] flat, input int i);
        return flat[i*16 +: 16];
    endfunction

    // ---------------- driver tasks ----------------
    // Sends the nbits LSBs of word MSB first; sclk low/high phases of 4 clk each.
    // vb_last raises vblank one clk after the final sclk rise so that the
    // vblank commit and the frame decode fall on the same clk.
    task automatic send_frame(input logic [31:0] word, input int nbits,
                              input bit close, input bit vb_last);
        spi_bus.spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bus.spi_mosi = word[i];
            repeat (4) @(negedge clk);
            spi_bus.spi_sclk = 1'b1;
            if (vb_last && i == 0) begin
                @(negedge clk);
                vblank = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_bus.spi_sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        if (close) begin
            spi_bus.spi_ss_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic pulse_vblank();
        vblank = 1'b1;
        repeat (6) @(negedge clk);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    int cp_base, cp1_base, fe_base, ae_base;

    initial begin
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        spi_bus.spi_ss_n = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: reset state
        check("rst_regs0", 32'(|regs0), 32'h0);
        check("rst_regs1", 32'(|regs1), 32'h0);
        check("rst_pending", 32'(pend0), 32'h0);
        check("rst_strobes", 32'({cp0, fe0, ae0}), 32'h0);
        check("rst_state", 32'(dbg0.state), 32'(IDLE));

        // 1: reset during a half-sent frame, then a full frame
        send_frame(32'h7CAFE >> 10, 10, 1'b0, 1'b0);
        rst_n = 1'b0;
        spi_bus.spi_ss_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_pending", 32'(pend0), 32'h0);
        check("midrst_reg7", 32'(reg_of(regs1, 7)), 32'h0);
        check("midrst_frame_err", 32'(fe0_n), 32'h0);
        send_frame(32'h7CAFE, 20, 1'b1, 1'b0);
        check("after_rst_pending", 32'(pend0), 32'h80);
        check("after_rst_imm_reg7", 32'(reg_of(regs1, 7)), 32'hCAFE);
        pulse_vblank();
        check("after_rst_reg7", 32'(reg_of(regs0, 7)), 32'hCAFE);

        // 2: write addr 3, commit on vblank rise
        send_frame(32'h3BEEF, 20, 1'b1, 1'b0);
        check("w3_reg3_pre", 32'(reg_of(regs0, 3)), 32'h0);
        check("w3_pending", 32'(pend0), 32'h08);
        cp_base = cp0_n;
        vblank = 1'b1;
        repeat (2) @(negedge clk);
        check("w3_commit_pulse", 32'(cp0), 32'h1);
        check("w3_reg3_post", 32'(reg_of(regs0, 3)), 32'hBEEF);
        check("w3_pending_post", 32'(pend0), 32'h0);
        repeat (4) @(negedge clk);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        check("w3_commit_width", 32'(cp0_n - cp_base), 32'h1);

        // 3: frame aborted after 10 bits
        fe_base = fe0_n;
        send_frame(32'h2AA, 10, 1'b1, 1'b0);
        check("abort_frame_err", 32'(fe0_n - fe_base), 32'h1);
        check("abort_pending", 32'(pend0), 32'h0);
        check("abort_reg3", 32'(reg_of(regs0, 3)), 32'hBEEF);
        send_frame(32'h45A5A, 20, 1'b1, 1'b0);
        check("abort_next_pending", 32'(pend0), 32'h10);
        pulse_vblank();
        check("abort_next_reg4", 32'(reg_of(regs0, 4)), 32'h5A5A);

        // 4: out-of-range address, then an overlong frame
        ae_base = ae0_n;
        fe_base = fe0_n;
        send_frame(32'h91234, 20, 1'b1, 1'b0);
        check("addr9_addr_err", 32'(ae0_n - ae_base), 32'h1);
        check("addr9_pending", 32'(pend0), 32'h0);
        send_frame(32'h54B4B6, 25, 1'b1, 1'b0);
        check("long_pending", 32'(pend0), 32'h04);
        check("long_no_err", 32'((ae0_n - ae_base) + (fe0_n - fe_base)), 32'h1);
        pulse_vblank();
        check("long_reg2", 32'(reg_of(regs0, 2)), 32'hA5A5);

        // 5: decode of addr 5 on the same clk as a vblank commit of addr 1
        send_frame(32'h17777, 20, 1'b1, 1'b0);
        check("align_pending1", 32'(pend0), 32'h02);
        send_frame(32'h50F0F, 20, 1'b1, 1'b1);
        check("align_reg1", 32'(reg_of(regs0, 1)), 32'h7777);
        check("align_pending5", 32'(pend0), 32'h20);
        check("align_reg5_pre", 32'(reg_of(regs0, 5)), 32'h0);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        pulse_vblank();
        check("align_reg5_post", 32'(reg_of(regs0, 5)), 32'h0F0F);
        check("align_pending_post", 32'(pend0), 32'h0);

        // 6: two writes to addr 0 before vblank; immediate-commit instance
        cp1_base = cp1_n;
        send_frame(32'h01111, 20, 1'b1, 1'b0);
        check("imm_reg0_first", 32'(reg_of(regs1, 0)), 32'h1111);
        check("imm_pending", 32'(pend1), 32'h0);
        check("vb_reg0_held", 32'(reg_of(regs0, 0)), 32'h0);
        send_frame(32'h02222, 20, 1'b1, 1'b0);
        check("imm_reg0_second", 32'(reg_of(regs1, 0)), 32'h2222);
        check("imm_commit_count", 32'(cp1_n - cp1_base), 32'h2);
        check("vb_pending0", 32'(pend0), 32'h01);
        pulse_vblank();
        check("vb_reg0_last_wins", 32'(reg_of(regs0, 0)), 32'h2222);
        check("imm_vblank_ignored", 32'(cp1_n - cp1_base), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
